// File: rtl/alu_iter.sv
//------------------------------------------------------------------------------
// Module   : alu_iter
// Purpose  : Execute-stage ALU. AND/OR/ADD/SUB/SLT in one cycle, MUL by an
//            iterative shift-add multiplier that stalls the pipeline.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             busy_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] c_OP_AND = 4'b0000;
    localparam logic [3:0] c_OP_OR  = 4'b0001;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0110;
    localparam logic [3:0] c_OP_SLT = 4'b0111;
    localparam logic [3:0] c_OP_MUL = 4'b1000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [WIDTH-1:0]  r_acc;
    logic [CW-1:0]     r_count;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_valid;

    logic              w_idle;
    logic              w_is_mul;
    logic              w_start;
    logic              w_issue;
    logic              w_last;
    logic              w_lt;
    logic [WIDTH-1:0]  w_alu_res;
    logic [WIDTH-1:0]  w_acc_nxt;

    assign w_idle   = (r_state == S_IDLE);
    assign w_is_mul = (ctrl_i == c_OP_MUL);
    assign w_start  = valid_i && w_idle && w_is_mul;
    assign w_issue  = valid_i && w_idle && !w_is_mul;
    assign w_last   = (r_count == c_LAST);
    assign w_lt     = ($signed(src1_i) < $signed(src2_i));
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_alu_res = '0;
        case (ctrl_i)
            c_OP_AND: w_alu_res = src1_i & src2_i;
            c_OP_OR:  w_alu_res = src1_i | src2_i;
            c_OP_ADD: w_alu_res = src1_i + src2_i;
            c_OP_SUB: w_alu_res = src1_i - src2_i;
            c_OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
            default:  w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_MUL;
            S_MUL:   if (w_last)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_issue) begin
                r_result <= w_alu_res;
                r_zero   <= (w_alu_res == '0);
                r_valid  <= 1'b1;
            end
            if (w_start) begin
                r_mcand  <= src1_i;
                r_mplier <= src2_i;
                r_acc    <= '0;
                r_count  <= '0;
            end
            if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_count  <= r_count + 1'b1;
                // Final iteration: publish the accumulator as it is being updated.
                if (w_last) begin
                    r_result <= w_acc_nxt;
                    r_zero   <= (w_acc_nxt == '0);
                    r_valid  <= 1'b1;
                    r_count  <= '0;
                end
            end
        end
    end

    assign result_o = r_result;
    assign zero_o   = r_zero;
    assign valid_o  = r_valid;
    assign busy_o   = (r_state == S_MUL);

endmodule

`default_nettype wire

// File: tb/tb_alu_iter.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_iter
// Purpose  : Self-checking bench for alu_iter with directed and random ops.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_iter;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             valid_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ctrl_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             valid_o;
    logic             busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    alu_iter #(.WIDTH(WIDTH)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .src1_i   (src1_i),
        .src2_i   (src2_i),
        .ctrl_i   (ctrl_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .valid_o  (valid_o),
        .busy_o   (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: straight arithmetic on the operation's definition.
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
        longint sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = {32'b0, a} * {32'b0, b};
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            4'b0110: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: return p[31:0];
            default: return 32'd0;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b);
        logic [31:0] exp;
        int busy_cnt;
        exp = ref_alu(c, a, b);
        @(negedge clk);
        valid_i = 1'b1; ctrl_i = c; src1_i = a; src2_i = b;
        @(posedge clk);
        #1 valid_i = 1'b0;
        if (c == 4'b1000) begin
            busy_cnt = 0;
            while (!valid_o && busy_cnt < 100) begin
                if (busy_o) busy_cnt++;
                @(posedge clk);
                #1;
            end
            chk({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(WIDTH));
            chk({tag, ".busy_at_done"}, 64'(busy_o), 64'd0);
        end
        chk({tag, ".valid"}, 64'(valid_o), 64'd1);
        chk({tag, ".result"}, 64'(result_o), 64'(exp));
        chk({tag, ".zero"}, 64'(zero_o), 64'(exp == 32'd0));
    endtask

    task automatic idle_check(input string tag, input logic [31:0] held);
        @(posedge clk);
        #1;
        chk({tag, ".valid_drop"}, 64'(valid_o), 64'd0);
        chk({tag, ".held"}, 64'(result_o), 64'(held));
    endtask

    initial begin
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [3:0]  legal [6];
        int          pulses;
        int          busy_cnt;
        legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010;
        legal[3] = 4'b0110; legal[4] = 4'b0111; legal[5] = 4'b1000;

        rst_i = 1'b1; valid_i = 1'b0; ctrl_i = '0; src1_i = '0; src2_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        chk("rst.result", 64'(result_o), 64'd0);
        chk("rst.zero",   64'(zero_o),   64'd0);
        chk("rst.valid",  64'(valid_o),  64'd0);
        chk("rst.busy",   64'(busy_o),   64'd0);

        run_op("add7_5", 4'b0010, 32'd7, 32'd5);
        idle_check("add7_5", 32'd12);
        run_op("sub5_5", 4'b0110, 32'd5, 32'd5);
        run_op("and",   4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0);
        run_op("or",    4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0);
        run_op("slt_m1_1", 4'b0111, 32'hFFFFFFFF, 32'd1);
        run_op("slt_1_m1", 4'b0111, 32'd1, 32'hFFFFFFFF);
        run_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'd1);
        run_op("mul_70015", 4'b1000, 32'h00010003, 32'd7);
        idle_check("mul_70015", 32'h00070015);
        run_op("mul_m3_4", 4'b1000, 32'hFFFFFFFD, 32'd4);
        run_op("illegal_0101", 4'b0101, 32'd3, 32'd4);

        // MUL with valid_i held high and an ADD presented while busy
        @(negedge clk);
        valid_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'h12345678; src2_i = 32'd1;
        @(posedge clk);
        #1 ctrl_i = 4'b0010; src1_i = 32'd9; src2_i = 32'd9;
        busy_cnt = 0;
        while (!valid_o && busy_cnt < 100) begin
            if (busy_o) busy_cnt++;
            @(posedge clk);
            #1;
        end
        chk("mulhold.busy_cycles", 64'(busy_cnt), 64'(WIDTH));
        chk("mulhold.result", 64'(result_o), 64'h12345678);
        src1_i = 32'd2; src2_i = 32'd2;
        @(posedge clk);
        #1 valid_i = 1'b0;
        chk("b2b_add.valid",  64'(valid_o),  64'd1);
        chk("b2b_add.result", 64'(result_o), 64'd4);

        // Non-MUL requests at one per cycle
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            a = $urandom; b = $urandom;
            valid_i = 1'b1; ctrl_i = 4'b0010; src1_i = a; src2_i = b;
            @(posedge clk);
            #1;
            chk("stream.valid",  64'(valid_o),  64'd1);
            chk("stream.result", 64'(result_o), 64'(ref_alu(4'b0010, a, b)));
        end
        valid_i = 1'b0;

        // Reset 10 cycles into a MUL
        @(negedge clk);
        valid_i = 1'b1; ctrl_i = 4'b1000; src1_i = 32'd1000; src2_i = 32'd1000;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        chk("midrst.busy",   64'(busy_o),   64'd0);
        chk("midrst.result", 64'(result_o), 64'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (valid_o) pulses++;
        end
        chk("midrst.no_valid", 64'(pulses), 64'd0);
        run_op("after_rst_add", 4'b0010, 32'd1, 32'd1);

        // Reset wins over a simultaneous request
        @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b1; ctrl_i = 4'b0010; src1_i = 32'd3; src2_i = 32'd3;
        @(posedge clk);
        #1 rst_i = 1'b0; valid_i = 1'b0;
        chk("rst_vs_req.valid",  64'(valid_o),  64'd0);
        chk("rst_vs_req.result", 64'(result_o), 64'd0);

        // Random operations
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
            else c = legal[$urandom_range(0, 5)];
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: begin a = 32'($urandom_range(0, 20)); b = 32'($urandom_range(0, 20)); end
                default: ;
            endcase
            run_op("rand", c, a, b);
            idle_check("rand", ref_alu(c, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_iter.md
# alu_iter

Execute-stage ALU sitting directly downstream of the ALU controller. It consumes the 4-bit ALU control code together with the two operands. It completes AND/OR/ADD/SUB/SLT in one cycle and MUL with an iterative shift-add multiplier. While a multiply is in flight it raises a stall request to the pipeline.

## Interface
Parameters:
- WIDTH, 32, operand/result width; MUL takes WIDTH iteration cycles

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  operation request, sampled on each rising edge
- src1_i  in  WIDTH  operand A (rs)
- src2_i  in  WIDTH  operand B (rt or extended immediate)
- ctrl_i  in  4  ALU control code
- result_o  out  WIDTH  registered result, held between completions
- zero_o  out  1  registered, 1 when the completing result == 0
- valid_o  out  1  one-cycle pulse: result_o/zero_o updated this cycle
- busy_o  out  1  stall request; high while a MUL is iterating

## Operation
- Control codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT (signed: result = 1 if $signed(src1) < $signed(src2), else 0)
  - 1000 MUL
  - any other code: result 0, zero_o 1, valid_o still pulses
- ADD/SUB wrap modulo 2^WIDTH. No overflow detection.
- MUL result is the low WIDTH bits of src1*src2. This is identical for signed and unsigned operands.
- States:
  - IDLE: accepts requests.
  - MUL: iterating; busy_o = 1.
- IDLE, valid_i=1, non-MUL code: at the edge, result_o/zero_o are loaded and valid_o <= 1. Stay in IDLE.
- IDLE, valid_i=1, ctrl_i=1000: at the edge, the following are captured, with no valid_o:
  - multiplicand <= src1
  - multiplier <= src2
  - accumulator <= 0
  - count <= 0
  - state <= MUL
- MUL, each edge, one iteration:
  - if multiplier[0], accumulator += multiplicand
  - multiplicand <<= 1
  - multiplier >>= 1
  - count++
- MUL, edge with count == WIDTH-1: the final iteration's accumulator is written to result_o, zero_o is set from it, valid_o <= 1, state <= IDLE.
- valid_i while in MUL: ignored. The pipeline holds the instruction because busy_o=1.
- busy_o is decoded combinationally from state (state == MUL).
- valid_o is high for exactly one cycle per accepted request.

## Timing
- Reset values: state IDLE, result_o 0, zero_o 0, valid_o 0, busy_o 0, count 0.
- Non-MUL latency: request sampled at edge E0; valid_o high in the cycle after E0.
- MUL latency:
  - request sampled at E0;
  - busy_o high from E0 to E32 (32 cycles for WIDTH=32);
  - valid_o high in the cycle after E32, with busy_o already 0 in that cycle.
- Back-to-back: a new request may be sampled in the same cycle that valid_o is high, since the state is IDLE then.
  - Non-MUL requests therefore sustain 1 per cycle.
  - A MUL is followed by a request at E33 at the earliest.
- Reset mid-MUL: at the reset edge, iteration is aborted, state goes to IDLE, busy_o falls, and no valid_o is produced. result_o returns to 0.
- Reset wins over valid_i at the same edge: the request is discarded.
- count is $clog2(WIDTH) bits wide. Completion is detected at WIDTH-1, with no wrap beyond it.

## Test plan
- Reset, then ADD 7+5 -> result_o=12, zero_o=0, valid_o pulses 1 cycle after the request; then SUB 5-5 -> result_o=0, zero_o=1.
- AND 0xF0F0F0F0&0x0FF00FF0 -> 0x00F000F0; OR of the same -> 0xFFF0FFF0; SLT -1 vs 1 -> 1; SLT 1 vs -1 -> 0; ADD 0xFFFFFFFF+1 -> 0, zero_o=1.
- MUL 0x0001_0003 * 7 -> busy_o high exactly 32 cycles, valid_o one cycle later with result 0x0007_0015; MUL -3*4 -> 0xFFFFFFF4.
- MUL 0x12345678 with valid_i held high and an ADD presented during busy -> ADD ignored, only one valid_o (MUL result 0x12345678*1 when src2=1); an ADD 2+2 presented in the valid_o cycle -> result 4 one cycle later.
- Assert rst_i 10 cycles into a MUL -> busy_o low, result_o 0, no valid_o ever; the next ADD 1+1 -> 2.
- ctrl_i=0101 with src1=3, src2=4 -> result_o=0, zero_o=1, valid_o pulses.
